// File: rtl/force_chk_pkg.sv
// rtl/force_chk_pkg.sv - shared types and defaults for the force/release checker
// Holds the checker state encoding, default parameter values and the settle
// counter type used by force_release_checker and its helpers.
package force_chk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FREE,
        FORCED,
        SETTLE,
        DONE
    } state_t;

    localparam int SETTLE_CYC_DEF = 1;
    localparam int ERR_W_DEF      = 16;

    // Settle windows are at most 15 cycles long.
    typedef logic [3:0] settle_cnt_t;

endpackage

// File: rtl/force_chk_edge.sv
// rtl/force_chk_edge.sv - registers the force enable and flags its edges
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset (clears the registered copy)
//   en    - force enable being watched
//   rise  - en is 1 this cycle and was 0 last cycle
//   fall  - en is 0 this cycle and was 1 last cycle
module force_chk_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic rise,
    output logic fall
);

    logic en_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en;
        end
    end

    assign rise = en & ~en_q;
    assign fall = ~en & en_q;

endmodule

// File: rtl/force_release_checker.sv
// rtl/force_release_checker.sv - checks a forceable upstream stage against its inputs
// Ports:
//   clk, rst_n - clock and synchronous active-low reset
//   run        - check window; a falling run closes the window
//   en         - upstream force enable
//   i_a        - upstream free-running data bit
//   force_val  - value the upstream stage drives while forced
//   o_a        - upstream output bus under check
//   err_cnt    - saturating count of mismatching checked cycles
//   err_map    - sticky per-bit mismatch flags
//   edge_cnt   - wrapping count of en edges inside the window
//   done, pass - one-cycle window-closed pulse and its verdict
module force_release_checker
    import force_chk_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int ERR_W      = ERR_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             en,
    input  logic             i_a,
    input  logic             force_val,
    input  logic [WIDTH-1:0] o_a,
    output logic [ERR_W-1:0] err_cnt,
    output logic [WIDTH-1:0] err_map,
    output logic [7:0]       edge_cnt,
    output logic             done,
    output logic             pass
);

    localparam settle_cnt_t SETTLE_LOAD = settle_cnt_t'(SETTLE_CYC);

    state_t           state;
    settle_cnt_t      settle_cnt;
    logic             rise;
    logic             fall;
    logic             en_edge;
    logic [WIDTH-1:0] expected;
    logic [WIDTH-1:0] diff;
    logic             mismatch;
    state_t           en_mode;

    force_chk_edge u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .rise  (rise),
        .fall  (fall)
    );

    assign en_edge = rise | fall;
    assign en_mode = en ? FORCED : FREE;

    // The upstream path is combinational, so the expected bus is built from
    // this cycle's inputs. Case inequality makes X/Z bits on o_a mismatch.
    always_comb begin
        expected = (state == FORCED) ? {WIDTH{force_val}} : {WIDTH{i_a}};
        diff     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            diff[i] = (o_a[i] !== expected[i]);
        end
    end

    assign mismatch = |diff;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            err_cnt    <= '0;
            err_map    <= '0;
            edge_cnt   <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            done <= 1'b0;
            pass <= 1'b0;
            case (state)
                IDLE: begin
                    if (run) begin
                        err_cnt  <= '0;
                        err_map  <= '0;
                        edge_cnt <= '0;
                        state    <= en_mode;
                    end
                end
                FREE, FORCED: begin
                    if (!run) begin
                        state      <= DONE;
                        settle_cnt <= '0;
                        done       <= 1'b1;
                        pass       <= (err_cnt == '0);
                    end else if (en_edge) begin
                        // The edge cycle itself is never compared.
                        edge_cnt <= edge_cnt + 8'd1;
                        if (SETTLE_CYC > 0) begin
                            state      <= SETTLE;
                            settle_cnt <= SETTLE_LOAD;
                        end else begin
                            state <= en_mode;
                        end
                    end else if (mismatch) begin
                        if (err_cnt != '1) begin
                            err_cnt <= err_cnt + ERR_W'(1);
                        end
                        err_map <= err_map | diff;
                    end
                end
                SETTLE: begin
                    if (!run) begin
                        state      <= DONE;
                        settle_cnt <= '0;
                        done       <= 1'b1;
                        pass       <= (err_cnt == '0);
                    end else if (en_edge) begin
                        edge_cnt   <= edge_cnt + 8'd1;
                        settle_cnt <= SETTLE_LOAD;
                    end else if (settle_cnt <= settle_cnt_t'(1)) begin
                        state      <= en_mode;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt - settle_cnt_t'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/force_release_checker.md
FORCE_RELEASE_CHECKER -- requirements
Module: force_release_checker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the monitored bus width.
REQ-002 The block SHALL have parameter SETTLE_CYC, default 1, giving the unchecked cycles after every en edge (range 0..15).
REQ-003 The block SHALL have parameter ERR_W, default 16, giving the error counter width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port run, input, 1 bit: check window; high means checking is active.
REQ-007 The block SHALL have port en, input, 1 bit: force enable of the upstream stage; high means forced.
REQ-008 The block SHALL have port i_a, input, 1 bit: the upstream free-running data input.
REQ-009 The block SHALL have port force_val, input, 1 bit: the value the upstream stage forces while en is high.
REQ-010 The block SHALL have port o_a, input, WIDTH bits: the upstream output bus under check.
REQ-011 The block SHALL have port err_cnt, output, ERR_W bits: saturating count of mismatching cycles.
REQ-012 The block SHALL have port err_map, output, WIDTH bits: sticky per-bit mismatch flags.
REQ-013 The block SHALL have port edge_cnt, output, 8 bits: wrapping count of en edges seen while checking.
REQ-014 The block SHALL have port done, output, 1 bit: high for exactly one cycle when a check window closes.
REQ-015 The block SHALL have port pass, output, 1 bit: valid with done; high when err_cnt is 0.

Function
REQ-016 The FSM SHALL have the states IDLE, FREE, FORCED, SETTLE and DONE.
REQ-017 IDLE SHALL go to FREE when run=1 and en=0, and to FORCED when run=1 and en=1; on entry, err_cnt, err_map and edge_cnt SHALL clear.
REQ-018 In FREE, the expected bus SHALL be {WIDTH{i_a}}, compared in the same cycle, because the upstream path is combinational.
REQ-019 In FORCED, the expected bus SHALL be {WIDTH{force_val}}.
REQ-020 An en edge SHALL be detected against a registered copy en_q.
- An edge in FREE or FORCED increments edge_cnt.
- If SETTLE_CYC>0, it enters SETTLE with down-counter = SETTLE_CYC.
- If SETTLE_CYC=0, it switches directly to the state matching the new en.
- The edge cycle itself is not checked.
REQ-021 SETTLE SHALL perform no compare and decrement its counter each cycle.
- At counter 1, it goes to FREE or FORCED according to the current en.
- A further en edge inside SETTLE increments edge_cnt and reloads the counter.
REQ-022 On a checked mismatch cycle:
- err_cnt increments by 1 and saturates at all-ones.
- err_map |= (o_a ^ expected).
- A cycle counts once regardless of how many bits differ.
REQ-023 run falling in FREE, FORCED or SETTLE SHALL go to DONE; that cycle is not checked.
REQ-024 DONE SHALL last one cycle with done=1 and pass=(err_cnt==0), then go to IDLE; err_cnt, err_map and edge_cnt hold until the next run.
REQ-025 An X/Z bit on o_a in a checked cycle SHALL count as a mismatch.
REQ-026 pass SHALL be 0 in every cycle except the DONE cycle.

Reset
REQ-027 With rst_n=0 at a clk edge, the following SHALL apply:
- state=IDLE, en_q=0, settle counter=0.
- err_cnt=0, err_map=0, edge_cnt=0, done=0, pass=0.
REQ-028 Reset mid-window SHALL abort without asserting done; the first post-reset cycle is IDLE.

Structure
REQ-029 Package force_chk_pkg SHALL hold:
- the state enum;
- the SETTLE_CYC and ERR_W defaults;
- the 4-bit settle counter type.
REQ-030 Sub-module force_chk_edge SHALL register en and output the rise/fall pulses; everything else stays in the top.

Verification
REQ-031 run=1, en=0, i_a toggling, o_a={8{i_a}} for 20 cycles, then run=0 -> done pulse, pass=1, err_cnt=0, edge_cnt=0.
REQ-032 en rises with force_val=1 and o_a=8'hFF after 1 cycle -> edge_cnt=1, no errors; o_a=8'hFE for 3 cycles in FORCED -> err_cnt=3, err_map=8'h01, pass=0 at done.
REQ-033 en falls, o_a holds the stale forced value in the settle cycle, then follows i_a -> err_cnt=0.
REQ-034 ERR_W=4, 20 mismatching cycles -> err_cnt=15 (saturated), pass=0.
REQ-035 rst_n=0 mid-window with err_cnt=5 -> next cycle err_cnt=0, state IDLE, no done pulse.
REQ-036 en toggling every cycle with SETTLE_CYC=2 -> no compare ever occurs, edge_cnt equals the toggle count modulo 256, err_cnt=0.
